// File: rtl/lock_rr_arbiter.sv
// lock_rr_arbiter: round-robin arbiter that merges N_CH four-phase req/ack
// channels onto one four-phase output channel. The owner may hold the grant
// across back-to-back transactions with its lock bit. A burst is capped at
// MAX_LOCK transactions (0 = no cap), so a lock can never starve the others.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | no owner; pick the next requester from the rr pointer
// WAIT_ACK_HI | req_out raised, waiting for ack_out to rise
// WAIT_REQ_LO | ack_in[g] raised, waiting for the owner to drop req_in[g]
// WAIT_ACK_LO | req_out dropped, waiting for ack_out to fall
// LOCKED      | owner keeps the grant between transactions of a burst
module lock_rr_arbiter #(
   parameter int N_CH     = 4,
   parameter int MAX_LOCK = 8,
   parameter int CNT_W    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          req_in,
   output logic [N_CH-1:0]          ack_in,
   input  logic [N_CH-1:0]          lock,
   output logic                     req_out,
   input  logic                     ack_out,
   output logic [N_CH-1:0]          grant,
   output logic [$clog2(N_CH)-1:0]  grant_id,
   output logic                     locked
);

   localparam int ID_W = $clog2(N_CH);
   localparam logic [ID_W:0]    N_W     = (ID_W+1)'(N_CH);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_CH - 1);
   localparam logic [CNT_W-1:0] MAX_L   = CNT_W'(MAX_LOCK);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ACK_HI,
      S_WAIT_REQ_LO,
      S_WAIT_ACK_LO,
      S_LOCKED
   } state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   ptr, ptr_nxt;
   logic [ID_W-1:0]   grant_id_nxt;
   logic [N_CH-1:0]   grant_nxt;
   logic [N_CH-1:0]   ack_in_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              req_out_nxt;
   logic              pick_vld;
   logic [ID_W-1:0]   pick_id;
   logic [ID_W:0]     sum;
   logic [ID_W:0]     idx;
   logic [ID_W-1:0]   next_ptr;
   logic              burst_ok;

   // Round-robin search: first requesting channel at or above ptr, with wrap.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      sum      = '0;
      idx      = '0;
      for (int i = 0; i < N_CH; i++) begin
         sum = {1'b0, ptr} + (ID_W+1)'(i);
         idx = (sum >= N_W) ? (sum - N_W) : sum;
         if (!pick_vld && req_in[idx[ID_W-1:0]]) begin
            pick_vld = 1'b1;
            pick_id  = idx[ID_W-1:0];
         end
      end
   end

   // Pointer successor of the current owner and burst-limit test.
   always_comb begin
      next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
      burst_ok = (MAX_LOCK == 0) || (cnt < MAX_L);
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      grant_id_nxt = grant_id;
      ptr_nxt      = ptr;
      cnt_nxt      = cnt;
      req_out_nxt  = req_out;
      ack_in_nxt   = ack_in;
      case (state)
         S_IDLE: begin
            if (pick_vld) begin
               grant_nxt          = '0;
               grant_nxt[pick_id] = 1'b1;
               grant_id_nxt       = pick_id;
               req_out_nxt        = 1'b1;
               cnt_nxt            = CNT_W'(1);
               state_nxt          = S_WAIT_ACK_HI;
            end
         end
         S_WAIT_ACK_HI: begin
            if (ack_out) begin
               ack_in_nxt = grant;
               state_nxt  = S_WAIT_REQ_LO;
            end
         end
         S_WAIT_REQ_LO: begin
            if (!req_in[grant_id]) begin
               req_out_nxt = 1'b0;
               state_nxt   = S_WAIT_ACK_LO;
            end
         end
         S_WAIT_ACK_LO: begin
            if (!ack_out) begin
               ack_in_nxt = '0;
               if (lock[grant_id] && burst_ok) begin
                  state_nxt = S_LOCKED;
               end else begin
                  state_nxt    = S_IDLE;
                  grant_nxt    = '0;
                  grant_id_nxt = '0;
                  ptr_nxt      = next_ptr;
               end
            end
         end
         S_LOCKED: begin
            // A new request beats a same-cycle unlock.
            if (req_in[grant_id]) begin
               req_out_nxt = 1'b1;
               if (MAX_LOCK != 0) cnt_nxt = cnt + CNT_W'(1);
               state_nxt   = S_WAIT_ACK_HI;
            end else if (!lock[grant_id]) begin
               state_nxt    = S_IDLE;
               grant_nxt    = '0;
               grant_id_nxt = '0;
               ptr_nxt      = next_ptr;
            end
         end
         default: begin
            state_nxt    = S_IDLE;
            grant_nxt    = '0;
            grant_id_nxt = '0;
            req_out_nxt  = 1'b0;
            ack_in_nxt   = '0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         ptr      <= '0;
         cnt      <= '0;
         grant    <= '0;
         grant_id <= '0;
         req_out  <= 1'b0;
         ack_in   <= '0;
         locked   <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
         grant    <= grant_nxt;
         grant_id <= grant_id_nxt;
         req_out  <= req_out_nxt;
         ack_in   <= ack_in_nxt;
         locked   <= (state_nxt == S_LOCKED);
      end
   end

endmodule

// File: tb/tb_lock_rr_arbiter.sv
// Bench for lock_rr_arbiter: requester/responder models drive the handshakes,
// scenarios push the expected owner sequence, a monitor pops and checks it.
module tb_lock_rr_arbiter;

   localparam int N  = 4;
   localparam int ML = 8;
   localparam int CW = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  req_in = '0;
   logic [N-1:0]  lock = '0;
   logic [N-1:0]  ack_in;
   logic [N-1:0]  grant;
   logic [IW-1:0] grant_id;
   logic          req_out;
   logic          ack_out = 1'b0;
   logic          locked;

   lock_rr_arbiter #(.N_CH(N), .MAX_LOCK(ML), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_in   (req_in),
      .ack_in   (ack_in),
      .lock     (lock),
      .req_out  (req_out),
      .ack_out  (ack_out),
      .grant    (grant),
      .grant_id (grant_id),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IW-1:0] id;
      logic          was_locked;
   } exp_t;

   exp_t         exp_q[$];
   int           total = 0;
   int           bad   = 0;
   int           pend[N];
   logic [N-1:0] busy    = '0;
   logic [N-1:0] lock_en = '0;
   logic [N-1:0] early   = '0;
   bit           mon_en  = 1'b0;
   logic         prev_req_out = 1'b0;
   logic         prev_locked  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic expect_txn(input int id, input bit was_locked);
      exp_t e;
      e.id = IW'(id);
      e.was_locked = was_locked;
      exp_q.push_back(e);
   endtask

   // One cycle of the environment: responder mirrors req_out onto ack_out,
   // each requester drops req on ack_in and re-raises once ack_in falls.
   task automatic tick();
      @(negedge clk);
      ack_out = req_out;
      for (int i = 0; i < N; i++) begin
         if (busy[i]) begin
            if (!ack_in[i]) begin
               busy[i] = 1'b0;
               pend[i]--;
               req_in[i] = (pend[i] > 0);
            end
         end else if (ack_in[i]) begin
            busy[i] = 1'b1;
            req_in[i] = 1'b0;
         end else begin
            req_in[i] = (pend[i] > 0);
         end
         lock[i] = lock_en[i] && (pend[i] > (early[i] ? 1 : 0));
      end
   endtask

   function automatic bit idle_now();
      bit ok;
      ok = (busy == '0) && (grant == '0) && !req_out && !locked;
      for (int i = 0; i < N; i++) if (pend[i] != 0) ok = 1'b0;
      return ok;
   endfunction

   task automatic run_idle(input string name, input int budget);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < budget) begin
         tick();
         n++;
         done = idle_now();
      end
      check({name, "_complete"}, 32'(done), 32'd1);
   endtask

   // Monitor: invariants every cycle, owner check on each new transaction.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         check("grant_onehot", 32'($onehot0(grant)), 32'd1);
         check("ack_in_owner", 32'(ack_in & ~grant), 32'd0);
         if (grant == '0) check("grant_id_idle", 32'(grant_id), 32'd0);
         else             check("grant_id_match", 32'(grant), 32'd1 << grant_id);
         if (req_out && !prev_req_out) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_txn: owner %0d with no expected transaction", grant_id);
            end else begin
               e = exp_q.pop_front();
               check("txn_owner", 32'(grant_id), 32'(e.id));
               check("txn_grant", 32'(grant), 32'd1 << e.id);
               check("txn_locked_before", 32'(prev_locked), 32'(e.was_locked));
               check("txn_locked_now", 32'(locked), 32'd0);
            end
         end
         prev_req_out = req_out;
         prev_locked  = locked;
      end
   end

   initial begin
      int s2[8];
      int n;
      s2 = '{3, 0, 1, 2, 3, 0, 1, 2};
      for (int i = 0; i < N; i++) pend[i] = 0;

      // reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_out", 32'(req_out), 32'd0);
      check("rst_ack_in", 32'(ack_in), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      rst = 1'b1;
      mon_en = 1'b1;

      // single transaction on ch2, 1-cycle latency; leaves ptr=3
      pend[2] = 1;
      expect_txn(2, 0);
      tick();
      tick();
      check("s1_latency_req_out", 32'(req_out), 32'd1);
      check("s1_latency_grant", 32'(grant), 32'b0100);
      run_idle("s1", 40);

      // fairness: all four request twice, rotation starts at ptr=3
      for (int i = 0; i < N; i++) pend[i] = 2;
      for (int k = 0; k < 8; k++) expect_txn(s2[k], 0);
      run_idle("s2", 200);

      // move ptr to 1 via a lone ch0 transaction
      pend[0] = 1;
      expect_txn(0, 0);
      run_idle("s3_pre", 40);

      // lock burst of 3 on ch1 while ch0/ch3 wait; then ch3 (ptr=2), ch0
      lock_en[1] = 1'b1;
      pend[1] = 3; pend[0] = 1; pend[3] = 1;
      expect_txn(1, 0); expect_txn(1, 1); expect_txn(1, 1);
      expect_txn(3, 0); expect_txn(0, 0);
      run_idle("s3", 200);
      lock_en = '0;

      // forced release after 8 on ch0, ch2 served before ch0 resumes
      lock_en[0] = 1'b1;
      pend[0] = 10; pend[2] = 2; pend[3] = 1;
      expect_txn(2, 0); expect_txn(3, 0);
      expect_txn(0, 0);
      for (int k = 0; k < 7; k++) expect_txn(0, 1);
      expect_txn(2, 0); expect_txn(0, 0); expect_txn(0, 1);
      run_idle("s4", 400);
      lock_en = '0;

      // same-cycle req_in[g]=1 and lock[g]=0 in LOCKED keeps the grant
      lock_en[1] = 1'b1; early[1] = 1'b1;
      pend[1] = 2; pend[3] = 1;
      expect_txn(1, 0); expect_txn(1, 1); expect_txn(3, 0);
      run_idle("s5", 100);
      lock_en = '0; early = '0;

      // ch1 moves ptr to 2, then reset while ch3 sits in WAIT_REQ_LO
      pend[1] = 1;
      expect_txn(1, 0);
      run_idle("s6_pre", 40);
      pend[3] = 1;
      expect_txn(3, 0);
      n = 0;
      while (ack_in[3] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("s6_reach_req_lo", 32'(ack_in[3]), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("s6_rst_req_out", 32'(req_out), 32'd0);
      check("s6_rst_ack_in", 32'(ack_in), 32'd0);
      check("s6_rst_grant", 32'(grant), 32'd0);
      check("s6_rst_locked", 32'(locked), 32'd0);
      for (int i = 0; i < N; i++) pend[i] = 0;
      busy = '0; req_in = '0; lock = '0; ack_out = 1'b0;
      rst = 1'b1;

      // first arbitration after reset starts from ch0
      pend[0] = 1; pend[3] = 1;
      expect_txn(0, 0); expect_txn(3, 0);
      run_idle("s6_post", 60);

      repeat (3) tick();
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
